// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, reset PC and branch-bus layout for the fetch stage
package if_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD       = 34;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  // Field positions inside br_bus; decode packs the bus with the same layout.
  localparam int BR_STALL_BIT  = 33;
  localparam int BR_TAKEN_BIT  = 32;
  localparam int BR_TARGET_MSB = 31;
  localparam int BR_TARGET_LSB = 0;

  typedef struct packed {
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  function automatic br_bus_t unpack_br_bus(input logic [BR_BUS_WD-1:0] bus);
    br_bus_t b;
    b.stall  = bus[BR_STALL_BIT];
    b.taken  = bus[BR_TAKEN_BIT];
    b.target = bus[BR_TARGET_MSB:BR_TARGET_LSB];
    return b;
  endfunction

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: next-PC select, sync SRAM read, decode handshake
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  br_bus_t     br;
  logic        to_fs_valid;
  logic        pfs_ready_go;
  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        buf_valid;
  logic [31:0] inst_buf;
  logic        br_pend;
  logic [31:0] br_pend_target;

  assign br           = unpack_br_bus(br_bus);
  assign to_fs_valid  = ~reset;
  assign pfs_ready_go = ~br.stall;
  assign fs_allowin   = ~fs_valid | ds_allowin;

  assign seq_pc = fs_pc + 32'd4;
  assign nextpc = br.taken ? br.target :
                  br_pend  ? br_pend_target :
                             seq_pc;

  assign inst_sram_en    = to_fs_valid & pfs_ready_go & fs_allowin;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  // The SRAM only holds its read data for one cycle, so a stalled word lives in inst_buf.
  assign fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_to_ds_valid = fs_valid;
  assign fs_to_ds_bus   = {fs_pc, fs_inst};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC - 32'd4;
      buf_valid      <= 1'b0;
      inst_buf       <= 32'h0;
      br_pend        <= 1'b0;
      br_pend_target <= 32'h0;
    end else begin
      if (fs_allowin) begin
        fs_valid <= inst_sram_en;
      end
      if (inst_sram_en) begin
        fs_pc <= nextpc;
      end

      if (fs_valid && ds_allowin) begin
        buf_valid <= 1'b0;
      end else if (fs_valid && !ds_allowin && !buf_valid) begin
        inst_buf  <= inst_sram_rdata;
        buf_valid <= 1'b1;
      end

      // A redirect that cannot issue now is remembered until the next issue slot.
      if (inst_sram_en) begin
        br_pend <= 1'b0;
      end else if (br.taken) begin
        br_pend        <= 1'b1;
        br_pend_target <= br.target;
      end
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage LoongArch pipeline: the producer side of the fetch→decode handshake and the consumer of the decode stage's branch bus. It generates the next PC (pre-IF), issues reads to a synchronous instruction SRAM, and presents `{pc, inst}` to decode with a valid/allowin handshake. It redirects on taken branches and holds fetch on branch stalls. A one-entry buffer keeps the fetched word alive across decode back-pressure.

## Interface
- `RESET_PC`, default 32'h1c00_0000: address of the first instruction fetched after reset.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ds_allowin` in 1: decode can accept an instruction this cycle.
- `br_bus` in 34: `{br_stall[33], br_taken[32], br_target[31:0]}`, combinational from decode.
- `fs_to_ds_valid` out 1: `fs_to_ds_bus` holds a valid instruction.
- `fs_to_ds_bus` out 64: `{fs_pc[63:32], fs_inst[31:0]}`.
- `inst_sram_en` out 1: read strobe.
- `inst_sram_we` out 4: always 0.
- `inst_sram_addr` out 32: read address (= nextpc).
- `inst_sram_wdata` out 32: always 0.
- `inst_sram_rdata` in 32: read data, valid the cycle after an `en` cycle.

## Operation
- **Pre-IF.**
  - `seq_pc = fs_pc + 4`, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0 allowed).
  - `nextpc` priority: `br_taken ? br_target : br_pend ? br_pend_target : seq_pc`.
  - `to_fs_valid = ~reset`. `pfs_ready_go = ~br_stall`.
- **Fetch issue:** `inst_sram_en = to_fs_valid & pfs_ready_go & fs_allowin`.
  - On issue, `fs_pc <= nextpc` and `fs_valid <= 1`.
  - If `fs_allowin` is 1 but there is no issue (br_stall), then `fs_valid <= 0`.
- **IF handshake.**
  - `fs_ready_go = 1`.
  - `fs_allowin = ~fs_valid | ds_allowin`.
  - `fs_to_ds_valid = fs_valid`.
- **Instruction buffer (`inst_buf`, `buf_valid`).**
  - `fs_inst = buf_valid ? inst_buf : inst_sram_rdata`.
  - Capture: `fs_valid & ~ds_allowin & ~buf_valid` → `inst_buf <= inst_sram_rdata`, `buf_valid <= 1`.
  - Clear: when `fs_valid & ds_allowin`.
- **Pending redirect (`br_pend`, `br_pend_target`).**
  - Set when `br_taken & ~inst_sram_en`; latches `br_target`.
  - Cleared on the next issue, which fetches `br_pend_target`.
  - `br_taken` on an issue cycle wins and also clears the pending redirect.
- **Delay slot:** the sequential instruction already in IF when a branch resolves is delivered normally. Decode owns its cancellation; IF never squashes.

## Timing
- **Reset values:** `fs_valid=0`, `fs_pc=RESET_PC-4`, `buf_valid=0`, `br_pend=0`.
- **Outputs during reset:**
  - `fs_to_ds_valid=0`.
  - `fs_to_ds_bus[63:32]=RESET_PC-4`.
  - `inst_sram_en=0`, `inst_sram_addr=RESET_PC`.
  - `we=0`, `wdata=0`.
- **First cycle after reset deasserts:** `en=1`, `addr=RESET_PC`. Next cycle: `fs_to_ds_valid=1`, `fs_pc=RESET_PC`.
- **Latency and throughput:** 1 cycle from `en` to `fs_to_ds_valid`; 1 instruction/cycle with no stalls.
- **Redirect:** `br_taken` in cycle N gives `addr=br_target` in cycle N if IF can issue, else in the first later issue cycle.
- **`br_stall=1`:** no issue. The IF instruction may still hand off. PC is unchanged.
- **Simultaneous `br_stall` and `br_taken`:** stall wins; target goes to `br_pend`.
- **Decode back-pressure for k cycles:** `fs_to_ds_bus` is stable for all k cycles and `en=0`; the SRAM output may change without effect.
- **Reset mid-operation:** all state clears asynchronously, including `buf_valid` and `br_pend`; no instruction is delivered until re-fetch.

## Structure
- **Shared package:**
  - `FS_TO_DS_BUS_WD=64`
  - `BR_BUS_WD=34`
  - `RESET_PC` default
  - bit-field positions of `br_bus`, shared with decode.
- **Sub-modules:** none needed; the buffer and pending redirect are a few flops in the stage.

## Test plan
- **Reset release:** `RESET_PC=32'h1c000000`, `ds_allowin=1`. Expect addrs 1c000000, 1c000004, 1c000008 on consecutive cycles; `fs_pc` follows one cycle later, with `fs_inst` = SRAM words.
- **Back-pressure:** `ds_allowin=0` for 3 cycles while `fs_pc=1c000008`, and the SRAM output is changed each cycle. Expect the bus held at `{1c000008, original word}` and `en=0`. After release, the next addr is 1c00000c.
- **Redirect:** `br_taken=1`, `br_target=1c000100` for one cycle with `ds_allowin=1`. Expect addr 1c000100 the same cycle, then 1c000104.
- **Pending redirect:** `br_taken=1`, `target=1c000200` while `ds_allowin=0` and `fs_valid=1`, then drop `br_taken` and raise `ds_allowin`. Expect the first issued addr to be 1c000200.
- **Branch stall:** `br_stall=1` for 2 cycles. Expect `en=0` and `fs_pc` unchanged. Then with `br_taken=1`, `target=1c000300`, expect addr 1c000300.
- **Async reset mid-stall:** assert reset while `buf_valid=1` and `br_pend=1`. Expect immediate `fs_to_ds_valid=0`; after release the first addr is `RESET_PC`.
